edge_event_monitor: RTL and testbench

Synthesizable RTL counterpart of the `$rose`/`$fell` sampling the team exercises in its SVA lectures. It watches a multi-bit level bus and produces per-bit single-cycle rise/fall pulses, saturating edge counters, and a valid/ready event record for a downstream consumer such as a scoreboard, interrupt aggregator or logger. It sits directly upstream of any checker or consumer that needs edge information as registered data rather than assertion sampling.

---
 rtl/edge_mon_pkg.sv | 39 +++
 rtl/sync_chain.sv | 41 ++++
 rtl/edge_event_monitor.sv | 136 +++++++++++++
 tb/tb_edge_event_monitor.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/edge_mon_pkg.sv
// Shared types and helpers for the edge event monitor.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Helpers work on a fixed MAX_W-bit domain so they can be shared by any
// instance; callers zero-extend their operands and truncate the result.
// WIDTH and CNT_W must therefore not exceed MAX_W.
package edge_mon_pkg;

    localparam int MAX_W = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Number of set bits in v (0..MAX_W).
    function automatic logic [5:0] popcount(input logic [MAX_W-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < MAX_W; i++) begin
            n = n + {5'b0, v[i]};
        end
        return n;
    endfunction

    // a + b clamped to 2^w - 1. The sum is formed one bit wider than the
    // operands so a carry out is seen as saturation rather than a wrap.
    function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input int               w);
        logic [MAX_W:0] sum;
        logic [MAX_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
        return (sum > lim) ? lim[MAX_W-1:0] : sum[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Per-bit flop synchronizer, N stages deep; pure passthrough when N = 0.
// Latency: N cycles from i_din to o_dout.
// Backpressure: none; samples every cycle.
//
// Ports: i_clk, i_rst_n (sync, active-low, stages reset to 0),
//        i_din [W-1:0] level input, o_dout [W-1:0] synchronized level.
module sync_chain #(
    parameter int N = 2,
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout
);

    if (N == 0) begin : g_pass
        assign o_dout = i_din;
        // Clock and reset are intentionally unused in the passthrough build.
        logic w_unused_clk_rst;
        assign w_unused_clk_rst = &{1'b0, i_clk, i_rst_n};
    end else begin : g_sync
        logic [W-1:0] r_stage [N];

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                for (int i = 0; i < N; i++) begin
                    r_stage[i] <= '0;
                end
            end else begin
                r_stage[0] <= i_din;
                for (int i = 1; i < N; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign o_dout = r_stage[N-1];
    end

endmodule

// File: rtl/edge_event_monitor.sv
// Turns a level bus into registered rise/fall pulses, saturating edge counts and an event record.
// Latency: din change sampled at edge k appears on pulses/counters/event at edge k+SYNC_STAGES.
// Backpressure: one-entry event register; new edges OR-merge into a stalled record and set sticky overflow.
//
// Ports: i_clk, i_rst_n (sync, active-low), i_din [WIDTH-1:0] monitored bus,
//        i_clr (clears counters + overflow), o_rise/o_fall [WIDTH-1:0] one-cycle pulses,
//        o_rise_cnt/o_fall_cnt [CNT_W-1:0] saturating bit-edge totals,
//        o_evt_valid/i_evt_ready/o_evt_data [2*WIDTH-1:0] = {rise_bits, fall_bits},
//        o_evt_overflow sticky merge flag. WIDTH and CNT_W are limited to 32.
module edge_event_monitor
    import edge_mon_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 0,
    parameter int CNT_W       = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [WIDTH-1:0]   i_din,
    input  logic               i_clr,
    output logic [WIDTH-1:0]   o_rise,
    output logic [WIDTH-1:0]   o_fall,
    output logic [CNT_W-1:0]   o_rise_cnt,
    output logic [CNT_W-1:0]   o_fall_cnt,
    output logic               o_evt_valid,
    input  logic               i_evt_ready,
    output logic [2*WIDTH-1:0] o_evt_data,
    output logic               o_evt_overflow
);

    logic [WIDTH-1:0]   w_s;
    logic [WIDTH-1:0]   w_rise_next;
    logic [WIDTH-1:0]   w_fall_next;
    logic [2*WIDTH-1:0] w_new;
    logic               w_new_any;
    logic               w_merge;
    logic [CNT_W-1:0]   w_rise_cnt_next;
    logic [CNT_W-1:0]   w_fall_cnt_next;

    state_t             r_state;
    logic [WIDTH-1:0]   r_prev;
    logic [WIDTH-1:0]   r_rise;
    logic [WIDTH-1:0]   r_fall;
    logic [CNT_W-1:0]   r_rise_cnt;
    logic [CNT_W-1:0]   r_fall_cnt;
    logic               r_evt_valid;
    logic [2*WIDTH-1:0] r_evt_data;
    logic               r_evt_overflow;

    sync_chain #(
        .N (SYNC_STAGES),
        .W (WIDTH)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_din   (i_din),
        .o_dout  (w_s)
    );

    // In INIT prev holds the reset value, not a real sample, so comparing
    // against it would report phantom rises on bits already high.
    always_comb begin
        w_rise_next = '0;
        w_fall_next = '0;
        if (r_state == ST_RUN) begin
            w_rise_next = w_s & ~r_prev;
            w_fall_next = ~w_s & r_prev;
        end
        w_new     = {w_rise_next, w_fall_next};
        w_new_any = |w_new;
        w_merge   = r_evt_valid && !i_evt_ready && w_new_any;

        w_rise_cnt_next = CNT_W'(sat_add(MAX_W'(r_rise_cnt),
                                         MAX_W'(popcount(MAX_W'(w_rise_next))),
                                         CNT_W));
        w_fall_cnt_next = CNT_W'(sat_add(MAX_W'(r_fall_cnt),
                                         MAX_W'(popcount(MAX_W'(w_fall_next))),
                                         CNT_W));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state        <= ST_INIT;
            r_prev         <= '0;
            r_rise         <= '0;
            r_fall         <= '0;
            r_rise_cnt     <= '0;
            r_fall_cnt     <= '0;
            r_evt_valid    <= 1'b0;
            r_evt_data     <= '0;
            r_evt_overflow <= 1'b0;
        end else begin
            // Both states capture the current sample; only RUN emits pulses.
            r_prev <= w_s;
            r_rise <= w_rise_next;
            r_fall <= w_fall_next;

            if (r_state == ST_INIT) begin
                r_state <= ST_RUN;
            end else begin
                r_state <= ST_RUN;
            end

            // Clear wins over this cycle's edges; those edges are not counted.
            if (i_clr) begin
                r_rise_cnt     <= '0;
                r_fall_cnt     <= '0;
                r_evt_overflow <= 1'b0;
            end else begin
                r_rise_cnt <= w_rise_cnt_next;
                r_fall_cnt <= w_fall_cnt_next;
                if (w_merge) begin
                    r_evt_overflow <= 1'b1;
                end
            end

            // Empty or draining this edge: take the new record (no bubble).
            // Stalled: fold new edges into the held record so none are lost.
            if (!r_evt_valid || i_evt_ready) begin
                r_evt_data  <= w_new;
                r_evt_valid <= w_new_any;
            end else if (w_new_any) begin
                r_evt_data  <= r_evt_data | w_new;
            end
        end
    end

    assign o_rise         = r_rise;
    assign o_fall         = r_fall;
    assign o_rise_cnt     = r_rise_cnt;
    assign o_fall_cnt     = r_fall_cnt;
    assign o_evt_valid    = r_evt_valid;
    assign o_evt_data     = r_evt_data;
    assign o_evt_overflow = r_evt_overflow;

endmodule

// File: tb/tb_edge_event_monitor.sv
// Directed bench for edge_event_monitor: event records checked through a scoreboard queue,
// pulses/counters/flags checked directly after each edge.
// WIDTH=4, SYNC_STAGES=0, CNT_W=8.
module tb_edge_event_monitor;

    localparam int W  = 4;
    localparam int CW = 8;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           clr       = 1'b0;
    logic           evt_ready = 1'b0;
    logic [W-1:0]   din       = 4'b0100;

    logic [W-1:0]   rise;
    logic [W-1:0]   fall;
    logic [CW-1:0]  rise_cnt;
    logic [CW-1:0]  fall_cnt;
    logic           evt_valid;
    logic [2*W-1:0] evt_data;
    logic           evt_overflow;

    edge_event_monitor #(
        .WIDTH       (W),
        .SYNC_STAGES (0),
        .CNT_W       (CW)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_din          (din),
        .i_clr          (clr),
        .o_rise         (rise),
        .o_fall         (fall),
        .o_rise_cnt     (rise_cnt),
        .o_fall_cnt     (fall_cnt),
        .o_evt_valid    (evt_valid),
        .i_evt_ready    (evt_ready),
        .o_evt_data     (evt_data),
        .o_evt_overflow (evt_overflow)
    );

    always #5 clk = ~clk;

    logic [2*W-1:0] exp_q [$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a transfer happens on the next posedge whenever
    // valid && ready is seen mid-cycle.
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL evt_unexpected: got 0x%0h, expected no event", evt_data);
            end else begin
                chk("evt_xfer", 32'(evt_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rise"},     32'(rise),         32'h0);
        chk({tag, "_fall"},     32'(fall),         32'h0);
        chk({tag, "_rise_cnt"}, 32'(rise_cnt),     32'h0);
        chk({tag, "_fall_cnt"}, 32'(fall_cnt),     32'h0);
        chk({tag, "_valid"},    32'(evt_valid),    32'h0);
        chk({tag, "_data"},     32'(evt_data),     32'h0);
        chk({tag, "_ovf"},      32'(evt_overflow), 32'h0);
    endtask

    initial begin
        // Reset with bit 2 already high.
        evt_ready = 1'b1;
        tick(); tick(); tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();                                     // INIT -> RUN
        chk("init_rise", 32'(rise), 32'h0);
        tick();                                     // first RUN comparison
        chk("run1_rise", 32'(rise), 32'h0);
        chk("run1_valid", 32'(evt_valid), 32'h0);

        // Single-bit rise then fall.
        din = 4'b0101; exp_q.push_back(8'b0001_0000);
        tick();
        chk("r0_rise", 32'(rise), 32'h1);
        chk("r0_rise_cnt", 32'(rise_cnt), 32'd1);
        chk("r0_valid", 32'(evt_valid), 32'h1);
        tick();
        chk("r0_pulse_width", 32'(rise), 32'h0);
        chk("r0_drained", 32'(evt_valid), 32'h0);
        din = 4'b0100; exp_q.push_back(8'b0000_0001);
        tick();
        chk("f0_fall", 32'(fall), 32'h1);
        chk("f0_fall_cnt", 32'(fall_cnt), 32'd1);
        tick();
        chk("f0_pulse_width", 32'(fall), 32'h0);

        // Saturation: rise 1 -> 253 -> 254 -> 255 (clamped), fall 1 -> 254 -> 255.
        din = 4'b0000; exp_q.push_back(8'b0000_0100);
        tick();
        chk("f2_fall_cnt", 32'(fall_cnt), 32'd2);
        for (int k = 0; k < 63; k++) begin
            din = 4'b1111; exp_q.push_back(8'b1111_0000);
            tick();
            din = 4'b0000; exp_q.push_back(8'b0000_1111);
            tick();
        end
        chk("loop_rise_cnt", 32'(rise_cnt), 32'd253);
        chk("loop_fall_cnt", 32'(fall_cnt), 32'd254);
        din = 4'b0001; exp_q.push_back(8'b0001_0000);
        tick();
        chk("sat_rise_254", 32'(rise_cnt), 32'd254);
        din = 4'b0000; exp_q.push_back(8'b0000_0001);
        tick();
        chk("sat_fall_255", 32'(fall_cnt), 32'd255);
        din = 4'b1111; exp_q.push_back(8'b1111_0000);
        tick();
        chk("sat_rise_pulse", 32'(rise), 32'hF);
        chk("sat_rise_255", 32'(rise_cnt), 32'd255);
        din = 4'b0000; exp_q.push_back(8'b0000_1111);
        tick();
        chk("sat_fall_hold", 32'(fall_cnt), 32'd255);

        // Backpressure merge and overflow.
        din = 4'b0100; exp_q.push_back(8'b0100_0000);
        tick();
        tick();
        evt_ready = 1'b0;
        din = 4'b0101;
        tick();
        chk("bp_valid", 32'(evt_valid), 32'h1);
        chk("bp_data1", 32'(evt_data), 32'h10);
        chk("bp_ovf0", 32'(evt_overflow), 32'h0);
        din = 4'b0001;
        tick();
        chk("bp_merge", 32'(evt_data), 32'h14);
        chk("bp_ovf1", 32'(evt_overflow), 32'h1);
        tick();
        chk("bp_hold_valid", 32'(evt_valid), 32'h1);
        chk("bp_hold_data", 32'(evt_data), 32'h14);
        exp_q.push_back(8'b0001_0100);
        evt_ready = 1'b1;
        tick();
        chk("bp_after_xfer", 32'(evt_valid), 32'h0);
        chk("bp_ovf_sticky", 32'(evt_overflow), 32'h1);

        // Clear on the same edge as a 2-bit rise.
        din = 4'b0000; exp_q.push_back(8'b0000_0001);
        tick();
        clr = 1'b1; din = 4'b0011; exp_q.push_back(8'b0011_0000);
        tick();
        clr = 1'b0;
        chk("clr_rise", 32'(rise), 32'h3);
        chk("clr_rise_cnt", 32'(rise_cnt), 32'h0);
        chk("clr_fall_cnt", 32'(fall_cnt), 32'h0);
        chk("clr_ovf", 32'(evt_overflow), 32'h0);
        chk("clr_valid", 32'(evt_valid), 32'h1);
        chk("clr_data", 32'(evt_data), 32'h30);
        tick();
        chk("clr_after_cnt", 32'(rise_cnt), 32'h0);
        chk("clr_after_valid", 32'(evt_valid), 32'h0);

        // Reset mid-operation with a held event and nonzero counter.
        evt_ready = 1'b0;
        din = 4'b0111;
        tick();
        chk("pre_rst_valid", 32'(evt_valid), 32'h1);
        chk("pre_rst_cnt", 32'(rise_cnt), 32'd1);
        rst_n = 1'b0;
        tick();
        chk_all_zero("midrst");
        rst_n = 1'b1;
        tick();
        chk("rerun_init_rise", 32'(rise), 32'h0);
        tick();
        chk("rerun_rise", 32'(rise), 32'h0);
        chk("rerun_fall", 32'(fall), 32'h0);
        chk("rerun_valid", 32'(evt_valid), 32'h0);
        evt_ready = 1'b1;
        din = 4'b0110; exp_q.push_back(8'b0000_0001);
        tick();
        chk("rerun_fall1", 32'(fall), 32'h1);
        chk("rerun_fall_cnt", 32'(fall_cnt), 32'd1);
        tick();
        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
